reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH shall default to 8 and set the register width in bits.
REQ-002 Parameter ADDR_WIDTH shall default to 3 and set the address width, giving 2**ADDR_WIDTH registers (8 by default).
REQ-003 CLK  input  1  shall be the single clock; all state changes shall occur on its rising edge.
REQ-004 RESET  input  1  shall be a synchronous, active-high reset.
REQ-005 IN  input  DATA_WIDTH  shall carry the write data (the ALU RESULT on writeback).
REQ-006 INADDRESS  input  ADDR_WIDTH  shall select the destination register.
REQ-007 WRITE  input  1  shall be the write enable, active-high.
REQ-008 OUT1ADDRESS  input  ADDR_WIDTH  shall select the register for read port 1.
REQ-009 OUT2ADDRESS  input  ADDR_WIDTH  shall select the register for read port 2.
REQ-010 REGOUT1  output  DATA_WIDTH  shall carry the read port 1 data, driving ALU DATA1.
REQ-011 REGOUT2  output  DATA_WIDTH  shall carry the read port 2 data, driving ALU DATA2.

Function
REQ-012 Reads shall be combinational: REGOUT1 = reg[OUT1ADDRESS] and REGOUT2 = reg[OUT2ADDRESS], with zero cycle latency and no clock dependency.
REQ-013 On a rising CLK edge with WRITE=1 and RESET=0, reg[INADDRESS] shall load IN; all other registers shall hold.
REQ-014 With WRITE=0, no register shall change.
REQ-015 Write latency: written data shall be visible on a read port starting the cycle after the edge (unless the bypass in REQ-021 is compiled in).
REQ-016 Both read ports may address the same register simultaneously; both shall return the identical value.
REQ-017 Reading and writing the same address in one cycle without bypass: the read port shall show the old value until the edge and the new value after it.
REQ-018 Every register index 0..2**ADDR_WIDTH-1 shall be writable, including 0; there shall be no hardwired-zero register.

Reset
REQ-019 On a rising CLK edge with RESET=1, all registers shall clear to 0, so REGOUT1 and REGOUT2 read 0 at any address from the next cycle.
REQ-020 RESET shall take priority over WRITE on the same edge; the write shall be discarded, not deferred.

Configuration
REQ-021 With macro REG_FILE_BYPASS_EN defined, while WRITE=1 and RESET=0, any read port whose address equals INADDRESS shall output IN combinationally in the same cycle.
REQ-022 Without REG_FILE_BYPASS_EN, read ports shall return stored contents only, as in REQ-017.
REQ-023 With bypass compiled in and RESET=1, the bypass shall be suppressed, so stored contents are returned.

Structure
REQ-024 The DATA_WIDTH and ADDR_WIDTH defaults shall live in the shared cpu_pkg package, alongside the ALU SELECT opcode constants (FORWARD=0, ADD=1, AND=2, OR=3).
REQ-025 One sub-module, reg_cell (a DATA_WIDTH register with synchronous clear and load enable), shall be instantiated once per register.
REQ-026 Address decode and the two read multiplexers shall reside in reg_file.

Verification
REQ-027 Reset: pulse RESET for 1 cycle, then sweep OUT1ADDRESS/OUT2ADDRESS over 0..7 -> all reads return 0.
REQ-028 Write/read: write 95 to reg 4 and 2 to reg 6; next cycle set OUT1ADDRESS=4, OUT2ADDRESS=6 -> REGOUT1=95, REGOUT2=2; set both addresses to 4 -> both return 95.
REQ-029 Write disable: with reg 4=95, apply IN=37, INADDRESS=4, WRITE=0 for 1 edge -> REGOUT1 at address 4 stays 95.
REQ-030 Reset priority: assert RESET=1 and WRITE=1 with IN=200 to reg 1 on the same edge -> reg 1 reads 0 afterward.
REQ-031 Same-cycle read/write: reg 3=10, then write IN=77 to reg 3 while OUT1ADDRESS=3 -> without bypass REGOUT1 is 10 before the edge and 77 after; with REG_FILE_BYPASS_EN it is 77 before the edge.
REQ-032 ALU integration: write 25 to reg 0 and 41 to reg 1, read them into the ALU with SELECT=1, and write RESULT back to reg 2 -> reg 2 reads 66.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry defaults and ALU SELECT opcodes.
// Pure declarations, no timing; no flow control.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;

    typedef enum logic [2:0] {
        FORWARD = 3'd0,
        ADD     = 3'd1,
        AND     = 3'd2,
        OR      = 3'd3
    } alu_sel_t;

    // Reference ALU behaviour; anything not in the opcode set yields zero.
    function automatic logic [DATA_WIDTH_DEF-1:0] alu_eval(
        input alu_sel_t                  sel,
        input logic [DATA_WIDTH_DEF-1:0] data1,
        input logic [DATA_WIDTH_DEF-1:0] data2
    );
        logic [DATA_WIDTH_DEF-1:0] res;
        res = '0;
        case (sel)
            FORWARD: res = data2;
            ADD:     res = data1 + data2;
            AND:     res = data1 & data2;
            OR:      res = data1 | data2;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One register-file entry: DATA_WIDTH flop with synchronous clear and load enable.
// Latency: loaded value appears one cycle after the edge; clear beats load; no backpressure.
module reg_cell
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 2**ADDR_WIDTH-entry register file, one write port and two combinational read ports.
// Latency: writes visible the cycle after the edge; REG_FILE_BYPASS_EN forwards IN same-cycle; no backpressure.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   load;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (WRITE && (INADDRESS == ADDR_WIDTH'(i))) begin
                load[i] = 1'b1;
            end
        end
    end

    // RESET drives every cell's clear, so a concurrent write is simply lost.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        reg_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .clk  (CLK),
            .clear(RESET),
            .load (load[g]),
            .d    (IN),
            .q    (regs[g])
        );
    end

`ifdef REG_FILE_BYPASS_EN
    logic bypass_en;
    assign bypass_en = WRITE && !RESET;

    always_comb begin
        REGOUT1 = regs[OUT1ADDRESS];
        REGOUT2 = regs[OUT2ADDRESS];
        if (bypass_en && (OUT1ADDRESS == INADDRESS)) begin
            REGOUT1 = IN;
        end
        if (bypass_en && (OUT2ADDRESS == INADDRESS)) begin
            REGOUT2 = IN;
        end
    end
`else
    always_comb begin
        REGOUT1 = regs[OUT1ADDRESS];
        REGOUT2 = regs[OUT2ADDRESS];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expected read data queued as stimulus is applied, popped at each compare.
module tb_reg_file;
    import cpu_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    reg_file dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN         (IN),
        .INADDRESS  (INADDRESS),
        .WRITE      (WRITE),
        .OUT1ADDRESS(OUT1ADDRESS),
        .OUT2ADDRESS(OUT2ADDRESS),
        .REGOUT1    (REGOUT1),
        .REGOUT2    (REGOUT2)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        INADDRESS = addr;
        IN        = data;
        WRITE     = 1'b1;
        step();
        WRITE     = 1'b0;
    endtask

    task automatic test_all_regs();
        for (int a = 0; a < 8; a++) begin
            do_write(3'(a), 8'(a * 17 + 3));
            exp_q.push_back(8'(a * 17 + 3));
        end
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (REGOUT1 !== exp) begin
                errors++;
                $display("FAIL all_regs addr=%0d got=%0d expected=%0d", a, REGOUT1, exp);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a);
            OUT2ADDRESS = 3'(7 - a);
            exp_q.push_back(8'd0);
            exp_q.push_back(8'd0);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (REGOUT1 !== exp) begin
                errors++;
                $display("FAIL reset_port1 addr=%0d got=%0d expected=%0d", a, REGOUT1, exp);
            end
            exp = exp_q.pop_front();
            checks++;
            if (REGOUT2 !== exp) begin
                errors++;
                $display("FAIL reset_port2 addr=%0d got=%0d expected=%0d", 7 - a, REGOUT2, exp);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(3'd4, 8'd95);
        do_write(3'd6, 8'd2);
        OUT1ADDRESS = 3'd4;
        OUT2ADDRESS = 3'd6;
        exp_q.push_back(8'd95);
        exp_q.push_back(8'd2);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL write_read_r4 got=%0d expected=%0d", REGOUT1, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT2 !== exp) begin
            errors++;
            $display("FAIL write_read_r6 got=%0d expected=%0d", REGOUT2, exp);
        end
        OUT2ADDRESS = 3'd4;
        exp_q.push_back(8'd95);
        exp_q.push_back(8'd95);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL same_addr_port1 got=%0d expected=%0d", REGOUT1, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT2 !== exp) begin
            errors++;
            $display("FAIL same_addr_port2 got=%0d expected=%0d", REGOUT2, exp);
        end
    endtask

    task automatic test_write_disable();
        IN          = 8'd37;
        INADDRESS   = 3'd4;
        WRITE       = 1'b0;
        OUT1ADDRESS = 3'd4;
        exp_q.push_back(8'd95);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL write_disable got=%0d expected=%0d", REGOUT1, exp);
        end
    endtask

    task automatic test_reset_priority();
        do_write(3'd1, 8'd55);
        RESET       = 1'b1;
        WRITE       = 1'b1;
        IN          = 8'd200;
        INADDRESS   = 3'd1;
        OUT1ADDRESS = 3'd1;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd0);
        step();
        RESET = 1'b0;
        WRITE = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL reset_priority got=%0d expected=%0d", REGOUT1, exp);
        end
        step();
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL reset_not_deferred got=%0d expected=%0d", REGOUT1, exp);
        end
    endtask

    task automatic test_same_cycle();
        do_write(3'd3, 8'd10);
        OUT1ADDRESS = 3'd3;
        IN          = 8'd77;
        INADDRESS   = 3'd3;
        WRITE       = 1'b1;
`ifdef REG_FILE_BYPASS_EN
        exp_q.push_back(8'd77);
`else
        exp_q.push_back(8'd10);
`endif
        exp_q.push_back(8'd77);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL same_cycle_before got=%0d expected=%0d", REGOUT1, exp);
        end
        step();
        WRITE = 1'b0;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL same_cycle_after got=%0d expected=%0d", REGOUT1, exp);
        end
    endtask

    task automatic test_alu();
        logic [7:0] result;
        do_write(3'd0, 8'd25);
        do_write(3'd1, 8'd41);
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd1;
        #1;
        result = alu_eval(ADD, REGOUT1, REGOUT2);
        do_write(3'd2, result);
        OUT1ADDRESS = 3'd2;
        exp_q.push_back(8'd66);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (REGOUT1 !== exp) begin
            errors++;
            $display("FAIL alu_writeback got=%0d expected=%0d", REGOUT1, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = 8'($urandom_range(1, 255));
        end
        WRITE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            INADDRESS = 3'(i + 4);
            IN        = vals[i];
            exp_q.push_back(vals[i]);
            step();
        end
        WRITE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OUT2ADDRESS = 3'(i + 4);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (REGOUT2 !== exp) begin
                errors++;
                $display("FAIL back_to_back addr=%0d got=%0d expected=%0d", i + 4, REGOUT2, exp);
            end
        end
    endtask

    initial begin
        RESET       = 1'b1;
        WRITE       = 1'b0;
        IN          = '0;
        INADDRESS   = '0;
        OUT1ADDRESS = '0;
        OUT2ADDRESS = '0;
        step();
        RESET = 1'b0;
        test_all_regs();
        test_reset();
        test_write_read();
        test_write_disable();
        test_reset_priority();
        test_same_cycle();
        test_alu();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
